// File: rtl/block_pixel_streamer.sv
// block_pixel_streamer
// Turns AXI read bursts (one burst per block row, one RGB pixel per beat)
// into an 8-bit grey pixel stream with block and frame markers.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for frame_start with a non-zero block count
//   STREAM | accepting beats; one output pixel per accepted beat
//   FLUSH  | all beats taken, waiting for the eof pixel to be accepted
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   frame_start        start pulse, honoured only in IDLE
//   blocks_per_frame   block count, latched when a frame starts
//   rdata/rvalid/rlast AXI read-data beat (R=[23:16] G=[15:8] B=[7:0])
//   rready             beat accept
//   pix_data/pix_valid output grey pixel, downstream handshake via pix_ready
//   pix_sob/eob/sof/eof block and frame markers, aligned with pix_data
//   busy               FSM not in IDLE
//   frame_done         one-cycle pulse after the eof pixel is accepted
//   burst_err          sticky rlast mismatch, cleared when a frame starts
module block_pixel_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_WIDTH  = 8,
    parameter int BLOCK_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [31:0]           blocks_per_frame,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready,
    output logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sob,
    output logic                  pix_eob,
    output logic                  pix_sof,
    output logic                  pix_eof,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  burst_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [31:0] B_LAST = 32'(BLOCK_SIZE - 1);
    localparam int SUM_W  = PIX_WIDTH + 2;
    localparam int PROD_W = SUM_W + 10;

    state_t state, next_state;

    logic [31:0] col, row, blk, blk_total;
    logic        col_last, row_last, blk_last;
    logic        beat_acc, pix_acc, start_ok, last_beat;

    logic [PIX_WIDTH-1:0] ch_r, ch_g, ch_b, mean;
    logic [SUM_W-1:0]     sum;
    logic [PROD_W-1:0]    prod;
    logic                 unused_top;

    assign col_last  = (col == B_LAST);
    assign row_last  = (row == B_LAST);
    assign blk_last  = (blk == blk_total - 32'd1);
    assign rready    = (state == S_STREAM) && (!pix_valid || pix_ready);
    assign beat_acc  = rvalid && rready;
    assign pix_acc   = pix_valid && pix_ready;
    assign start_ok  = (state == S_IDLE) && frame_start && (blocks_per_frame != 32'd0);
    assign last_beat = beat_acc && col_last && row_last && blk_last;
    assign busy      = (state != S_IDLE);

    // Divide by 3 as multiply-and-shift: exact for every sum 0..765.
    assign ch_r       = rdata[3*PIX_WIDTH-1:2*PIX_WIDTH];
    assign ch_g       = rdata[2*PIX_WIDTH-1:PIX_WIDTH];
    assign ch_b       = rdata[PIX_WIDTH-1:0];
    assign sum        = SUM_W'(ch_r) + SUM_W'(ch_g) + SUM_W'(ch_b);
    assign prod       = PROD_W'(sum) * PROD_W'(683);
    assign mean       = PIX_WIDTH'(prod >> 11);
    assign unused_top = ^rdata[DATA_WIDTH-1:3*PIX_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_ok)              next_state = S_STREAM;
            S_STREAM: if (last_beat)             next_state = S_FLUSH;
            S_FLUSH:  if (pix_acc && pix_eof)    next_state = S_IDLE;
            default:                             next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            blk       <= '0;
            blk_total <= '0;
        end else if (start_ok) begin
            col       <= '0;
            row       <= '0;
            blk       <= '0;
            blk_total <= blocks_per_frame;
        end else if (beat_acc) begin
            col <= col_last ? '0 : col + 32'd1;
            if (col_last) begin
                row <= row_last ? '0 : row + 32'd1;
                if (row_last) begin
                    blk <= blk_last ? '0 : blk + 32'd1;
                end
            end
        end
    end

    // Output register: loads on every accepted beat, drains when downstream
    // takes the pixel; markers are computed from the pre-increment counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_sob    <= 1'b0;
            pix_eob    <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eof    <= 1'b0;
            frame_done <= 1'b0;
            burst_err  <= 1'b0;
        end else begin
            frame_done <= (state == S_FLUSH) && pix_acc && pix_eof;
            if (beat_acc) begin
                pix_valid <= 1'b1;
                pix_data  <= mean;
                pix_sob   <= (col == '0) && (row == '0);
                pix_eob   <= col_last && row_last;
                pix_sof   <= (col == '0) && (row == '0) && (blk == '0);
                pix_eof   <= col_last && row_last && blk_last;
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end
            if (start_ok) begin
                burst_err <= 1'b0;
            end else if (beat_acc && (rlast != col_last)) begin
                burst_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_pixel_streamer.sv
// Self-checking bench for block_pixel_streamer: randomized beats and
// backpressure, compared every cycle against an index-based frame model.
module tb_block_pixel_streamer;

    localparam int BS  = 8;
    localparam int BPX = BS * BS;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [31:0] blocks_per_frame;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sob, pix_eob, pix_sof, pix_eof;
    logic        busy;
    logic        frame_done;
    logic        burst_err;

    block_pixel_streamer #(.DATA_WIDTH(32), .PIX_WIDTH(8), .BLOCK_SIZE(BS)) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .blocks_per_frame (blocks_per_frame),
        .rdata            (rdata),
        .rvalid           (rvalid),
        .rlast            (rlast),
        .rready           (rready),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_sob          (pix_sob),
        .pix_eob          (pix_eob),
        .pix_sof          (pix_sof),
        .pix_eof          (pix_eof),
        .busy             (busy),
        .frame_done       (frame_done),
        .burst_err        (burst_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver-owned expectations (hand-computed literals)
    int          drv_exp_pix;
    int          drv_exp_blk;
    logic        drv_exp_err;
    logic        lit_on;
    int          drv_timeout;
    logic [31:0] lit_word [5];
    logic [7:0]  lit_exp  [5];

    // monitor-owned model and counters
    int          ntests;
    int          nfail;
    logic [11:0] q[$];
    logic        active;
    int          beat_idx;
    int          tot;
    logic        err_m;
    logic        exp_done;
    logic        prev_rst;
    logic        prev_stall;
    logic [12:0] prev_snap;
    int          npix, nsob, neob, pix_idx, seen_to;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] grey(input logic [31:0] w);
        int s;
        s = int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
        return 8'(s / 3);
    endfunction

    always @(negedge clk) begin
        logic        was_active;
        logic [11:0] e;
        logic [11:0] got;
        int          k;
        if (rst) begin
            q.delete();
            active     = 1'b0;
            beat_idx   = 0;
            tot        = 0;
            err_m      = 1'b0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            was_active = active;
            if (prev_rst) begin
                check("reset_outputs",
                      {rready, pix_valid, pix_data, pix_sob, pix_eob, pix_sof, pix_eof,
                       busy, frame_done, burst_err}, 64'd0);
                prev_rst = 1'b0;
            end
            if (drv_timeout != seen_to) begin
                check("timeout", 1, 0);
                seen_to = drv_timeout;
            end
            check("busy", busy, active);
            check("rready", rready, active && (beat_idx < tot) && (!pix_valid || pix_ready));
            check("burst_err", burst_err, err_m);
            check("frame_done", frame_done, exp_done);
            if (exp_done) check("burst_err_final", burst_err, drv_exp_err);
            exp_done = 1'b0;
            if (prev_stall)
                check("stall_hold", {pix_valid, pix_data, pix_sob, pix_eob, pix_sof, pix_eof}, prev_snap);

            if (pix_valid && pix_ready) begin
                got = {pix_data, pix_sob, pix_eob, pix_sof, pix_eof};
                if (q.size() == 0) begin
                    check("pixel_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("pixel", got, e);
                end
                if (lit_on && pix_idx < 5) check("lit_data", pix_data, lit_exp[pix_idx]);
                npix++;
                nsob += int'(pix_sob);
                neob += int'(pix_eob);
                pix_idx++;
                if (pix_eof) begin
                    exp_done = 1'b1;
                    active   = 1'b0;
                    check("frame_pixels", npix, drv_exp_pix);
                    check("frame_sob", nsob, drv_exp_blk);
                    check("frame_eob", neob, drv_exp_blk);
                    check("queue_empty", q.size(), 0);
                end
            end

            if (rvalid && rready) begin
                k = beat_idx;
                q.push_back({grey(rdata), (k % BPX) == 0, (k % BPX) == BPX - 1,
                             k == 0, k == tot - 1});
                if (rlast != ((k % BS) == BS - 1)) err_m = 1'b1;
                beat_idx++;
            end

            if (frame_start && !was_active && blocks_per_frame != 0) begin
                active   = 1'b1;
                tot      = int'(blocks_per_frame) * BPX;
                beat_idx = 0;
                err_m    = 1'b0;
                npix     = 0;
                nsob     = 0;
                neob     = 0;
                pix_idx  = 0;
            end

            prev_stall = pix_valid && !pix_ready;
            prev_snap  = {pix_valid, pix_data, pix_sob, pix_eob, pix_sof, pix_eof};
        end
    end

    function automatic logic ready_for(input int mode, input logic cur);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ~cur;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic start_frame(input int nblk);
        blocks_per_frame = 32'(nblk);
        frame_start      = 1'b1;
        @(posedge clk); #1;
        frame_start      = 1'b0;
        blocks_per_frame = $urandom;
    endtask

    task automatic stream(input int nbeats, input int mode, input int bad_beat,
                          input int fs_beat, input logic use_lit);
        int          sent;
        int          guard;
        logic [31:0] word;
        sent  = 0;
        guard = 0;
        word  = use_lit ? lit_word[0] : $urandom;
        while (sent < nbeats && guard < 20000) begin
            rvalid      = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdata       = word;
            rlast       = ((sent % BS) == BS - 1) != (sent == bad_beat);
            pix_ready   = ready_for(mode, pix_ready);
            frame_start = (sent == fs_beat);
            @(negedge clk);
            if (rvalid && rready) begin
                sent++;
                word = (use_lit && sent < 5) ? lit_word[sent] : $urandom;
            end
            @(posedge clk); #1;
            guard++;
        end
        rvalid      = 1'b0;
        rlast       = 1'b0;
        frame_start = 1'b0;
        if (guard >= 20000) drv_timeout++;
    endtask

    task automatic finish_frame(input int mode);
        int guard;
        guard = 0;
        while (!frame_done && guard < 2000) begin
            pix_ready = ready_for(mode, pix_ready);
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) drv_timeout++;
        pix_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic full_frame(input int nblk, input int mode, input int bad_beat,
                              input int fs_beat, input logic use_lit);
        drv_exp_pix = nblk * BPX;
        drv_exp_blk = nblk;
        drv_exp_err = (bad_beat >= 0);
        lit_on      = use_lit;
        start_frame(nblk);
        stream(nblk * BPX, mode, bad_beat, fs_beat, use_lit);
        finish_frame(mode);
        lit_on = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        ntests = 0; nfail = 0; seen_to = 0; drv_timeout = 0;
        active = 1'b0; beat_idx = 0; tot = 0; err_m = 1'b0; exp_done = 1'b0;
        prev_rst = 1'b0; prev_stall = 1'b0; prev_snap = '0;
        npix = 0; nsob = 0; neob = 0; pix_idx = 0;
        drv_exp_pix = 0; drv_exp_blk = 0; drv_exp_err = 1'b0; lit_on = 1'b0;
        lit_word[0] = 32'h00FF_FFFF; lit_exp[0] = 8'd255;
        lit_word[1] = 32'h0001_0203; lit_exp[1] = 8'd2;
        lit_word[2] = 32'h00FF_0000; lit_exp[2] = 8'd85;
        lit_word[3] = 32'hAB00_0000; lit_exp[3] = 8'd0;
        lit_word[4] = 32'h0000_0000; lit_exp[4] = 8'd0;
        rst = 1'b1; frame_start = 1'b0; blocks_per_frame = '0;
        rdata = '0; rvalid = 1'b0; rlast = 1'b0; pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // full-rate 16x16 frame with the literal data words up front
        full_frame(4, 0, -1, -1, 1'b1);
        // pix_ready toggling every cycle
        full_frame(4, 1, -1, -1, 1'b0);
        // extra rlast on beat 5 of the first burst
        full_frame(4, 0, 5, -1, 1'b0);

        // zero block count: must stay idle while beats are offered
        start_frame(0);
        rvalid = 1'b1;
        rdata  = $urandom;
        repeat (10) @(posedge clk);
        #1 rvalid = 1'b0;

        // frame_start mid-stream with random backpressure and rvalid gaps
        full_frame(2, 2, -1, 40, 1'b0);

        // reset after 100 beats, then a clean frame
        drv_exp_pix = 4 * BPX;
        start_frame(4);
        stream(100, 0, -1, -1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        full_frame(4, 2, -1, -1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            full_frame(int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), -1, -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
